// File: rtl/lsu_align.sv
// Load/store alignment unit between the core and a word-organised data memory.
// Lane-shifts stores, extends loads and splits word-crossing accesses into two cycles.
module lsu_align #(
  parameter bit          MISALIGN_EN = 1'b1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [ADDR_W-1:0] StoreData,
  input  logic [ADDR_W-1:0] ReadData,
  output logic              WE,
  output logic [ADDR_W-1:0] DataAdr,
  output logic [ADDR_W-1:0] WriteData,
  output logic [3:0]        web,
  output logic [ADDR_W-1:0] LoadResult,
  output logic              Stall,
  output logic              Done,
  output logic              Fault
);

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  state_e state_q, state_d;

  // Holding registers for the second half of a split access.
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] store_data_q;
  logic [ADDR_W-1:0] held_word_q;
  logic [2:0]        funct3_q;
  logic              mem_write_q;

  logic              in_second;
  logic [ADDR_W-1:0] cur_adr;
  logic [ADDR_W-1:0] cur_sd;
  logic [2:0]        cur_f3;
  logic              cur_wr;
  logic [1:0]        off;
  logic [4:0]        shamt;
  logic [3:0]        size_mask;
  logic [2:0]        size_bytes;
  logic              legal;
  logic              misaligned;
  logic [7:0]        lane_mask;
  logic [2*ADDR_W-1:0] wd_wide;
  logic [2*ADDR_W-1:0] rd_wide;
  logic [ADDR_W-1:0] rd_word;
  logic [ADDR_W-1:0] ext_word;
  logic [ADDR_W-3:0] next_word;

  assign in_second = (state_q == StSecond);
  assign cur_adr   = in_second ? adr_q        : Adr;
  assign cur_sd    = in_second ? store_data_q : StoreData;
  assign cur_f3    = in_second ? funct3_q     : Funct3;
  assign cur_wr    = in_second ? mem_write_q  : MemWrite;
  assign off       = cur_adr[1:0];
  assign shamt     = {off, 3'b000};

  always_comb begin
    size_mask  = 4'b0000;
    size_bytes = 3'd0;
    legal      = 1'b0;
    unique case (cur_f3)
      3'b000: begin size_mask = 4'b0001; size_bytes = 3'd1; legal = 1'b1;    end
      3'b001: begin size_mask = 4'b0011; size_bytes = 3'd2; legal = 1'b1;    end
      3'b010: begin size_mask = 4'b1111; size_bytes = 3'd4; legal = 1'b1;    end
      3'b100: begin size_mask = 4'b0001; size_bytes = 3'd1; legal = !cur_wr; end
      3'b101: begin size_mask = 4'b0011; size_bytes = 3'd2; legal = !cur_wr; end
      default: begin size_mask = 4'b0000; size_bytes = 3'd0; legal = 1'b0;   end
    endcase
  end

  // Split is decided by the byte span crossing a word boundary, not natural alignment.
  assign misaligned = (({1'b0, off} + size_bytes) > 3'd4);

  // Low half of each wide vector serves the first access, high half the second.
  assign lane_mask = {4'b0000, size_mask} << off;
  assign wd_wide   = {{ADDR_W{1'b0}}, cur_sd} << shamt;
  assign rd_wide   = in_second ? {ReadData, held_word_q} : {{ADDR_W{1'b0}}, ReadData};
  assign rd_word   = ADDR_W'(rd_wide >> shamt);
  assign next_word = adr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);

  always_comb begin
    ext_word = '0;
    unique case (cur_f3)
      3'b000:  ext_word = {{(ADDR_W-8){rd_word[7]}}, rd_word[7:0]};
      3'b001:  ext_word = {{(ADDR_W-16){rd_word[15]}}, rd_word[15:0]};
      3'b010:  ext_word = rd_word;
      3'b100:  ext_word = {{(ADDR_W-8){1'b0}}, rd_word[7:0]};
      3'b101:  ext_word = {{(ADDR_W-16){1'b0}}, rd_word[15:0]};
      default: ext_word = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    WE         = 1'b0;
    DataAdr    = '0;
    WriteData  = '0;
    web        = 4'b0000;
    LoadResult = '0;
    Stall      = 1'b0;
    Done       = 1'b0;
    Fault      = 1'b0;
    if (RESET) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MemReq) begin
            if (!legal || (misaligned && !MISALIGN_EN)) begin
              Fault = 1'b1;
            end else begin
              DataAdr   = {cur_adr[ADDR_W-1:2], 2'b00};
              WE        = cur_wr;
              web       = lane_mask[3:0];
              WriteData = wd_wide[ADDR_W-1:0];
              if (misaligned) begin
                Stall   = 1'b1;
                state_d = StSecond;
              end else begin
                Done       = 1'b1;
                LoadResult = ext_word;
              end
            end
          end
        end
        StSecond: begin
          DataAdr    = {next_word, 2'b00};
          WE         = mem_write_q;
          web        = lane_mask[7:4];
          WriteData  = wd_wide[2*ADDR_W-1:ADDR_W];
          LoadResult = ext_word;
          Done       = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      store_data_q <= '0;
      held_word_q  <= '0;
      funct3_q     <= 3'b000;
      mem_write_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d == StSecond) begin
        adr_q        <= Adr;
        store_data_q <= StoreData;
        held_word_q  <= ReadData;
        funct3_q     <= Funct3;
        mem_write_q  <= MemWrite;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a small byte-enabled word memory model.
// A second instance with splitting disabled checks the fault path.
module tb_lsu_align;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemReq, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Adr, StoreData, ReadData;
  logic        WE, Stall, Done, Fault;
  logic [31:0] DataAdr, WriteData, LoadResult;
  logic [3:0]  web;
  logic        nm_we, nm_stall, nm_done, nm_fault;
  logic [31:0] nm_adr, nm_wd, nm_lr;
  logic [3:0]  nm_web;

  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  lsu_align #(.MISALIGN_EN(1'b1), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .MemReq(MemReq), .MemWrite(MemWrite), .Funct3(Funct3),
    .Adr(Adr), .StoreData(StoreData), .ReadData(ReadData), .WE(WE), .DataAdr(DataAdr),
    .WriteData(WriteData), .web(web), .LoadResult(LoadResult), .Stall(Stall), .Done(Done),
    .Fault(Fault)
  );

  lsu_align #(.MISALIGN_EN(1'b0), .ADDR_W(32)) dut_nm (
    .CLK(CLK), .RESET(RESET), .MemReq(MemReq), .MemWrite(MemWrite), .Funct3(Funct3),
    .Adr(Adr), .StoreData(StoreData), .ReadData(ReadData), .WE(nm_we), .DataAdr(nm_adr),
    .WriteData(nm_wd), .web(nm_web), .LoadResult(nm_lr), .Stall(nm_stall), .Done(nm_done),
    .Fault(nm_fault)
  );

  assign ReadData = mem[DataAdr[7:2]];

  always @(posedge CLK) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (WE) begin
      for (int i = 0; i < 4; i++) begin
        if (web[i]) mem[DataAdr[7:2]][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    MemReq = 1'b0;
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge CLK); #1;
    pl_en  = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    MemReq = 1'b1; MemWrite = wr; Funct3 = f3; Adr = a; StoreData = sd;
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    drive(1'b1, F_W, 32'h13, 32'hAABBCCDD);
    step(); step();
    @(negedge CLK);
    vectors++;
    if ({WE, web, Stall, Done, Fault} !== 8'h00 || DataAdr !== 32'h0 || WriteData !== 32'h0
        || LoadResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b web=%b st=%b dn=%b ft=%b adr=%h wd=%h lr=%h",
               WE, web, Stall, Done, Fault, DataAdr, WriteData, LoadResult);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; MemReq = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({WE, web, Stall, Done, Fault} !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_outputs got %b want 00000000", {WE, web, Stall, Done, Fault});
    end
    step();
  endtask

  task automatic test_load_byte;
    logic [2:0]  f3s [3] = '{F_B, F_B, F_BU};
    logic [31:0] as  [3] = '{32'h11, 32'h13, 32'h13};
    logic [31:0] exp [3] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080};
    preload(6'd4, 32'h80F17F02);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, f3s[i], as[i], 32'h0);
      @(negedge CLK);
      vectors++;
      if (LoadResult !== exp[i] || {Done, Stall, WE} !== 3'b100) begin
        miscompares++;
        $display("FAIL load_byte_%0d got lr=%h dn/st/we=%b want lr=%h 100",
                 i, LoadResult, {Done, Stall, WE}, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_store_half;
    drive(1'b1, F_H, 32'h12, 32'h1234ABCD);
    @(negedge CLK);
    vectors++;
    if ({WE, web, Done, Stall} !== 7'b1_1100_10 || WriteData !== 32'hABCD0000) begin
      miscompares++;
      $display("FAIL sh_12 got we=%b web=%b dn=%b st=%b wd=%h", WE, web, Done, Stall, WriteData);
    end
    step();
    MemReq = 1'b0;
    vectors++;
    if (mem[4] !== 32'hABCD7F02) begin
      miscompares++;
      $display("FAIL sh_12_mem got %h want abcd7f02", mem[4]);
    end
  endtask

  task automatic test_misaligned_store;
    preload(6'd5, 32'h0);
    drive(1'b1, F_W, 32'h13, 32'hAABBCCDD);
    @(negedge CLK);
    vectors++;
    if ({WE, web, Stall, Done} !== 7'b1_1000_10 || WriteData !== 32'hDD000000
        || DataAdr !== 32'h10) begin
      miscompares++;
      $display("FAIL sw_13_first got we=%b web=%b st=%b dn=%b wd=%h adr=%h",
               WE, web, Stall, Done, WriteData, DataAdr);
    end
    step();
    drive(1'b0, F_B, 32'h3C, 32'h0);  // core inputs must be ignored in the second half
    MemReq = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({WE, web, Stall, Done} !== 7'b1_0111_01 || WriteData !== 32'h00AABBCC
        || DataAdr !== 32'h14) begin
      miscompares++;
      $display("FAIL sw_13_second got we=%b web=%b st=%b dn=%b wd=%h adr=%h",
               WE, web, Stall, Done, WriteData, DataAdr);
    end
    step();
    drive(1'b0, F_W, 32'h10, 32'h0);
    @(negedge CLK);
    vectors++;
    if (LoadResult !== 32'hDDCD7F02 || Done !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_13_lw10 got %h want ddcd7f02", LoadResult);
    end
    step();
    MemReq = 1'b0;
    vectors++;
    if (mem[5] !== 32'h00AABBCC) begin
      miscompares++;
      $display("FAIL sw_13_mem14 got %h want 00aabbcc", mem[5]);
    end
  endtask

  task automatic test_misaligned_load;
    preload(6'd4, 32'h44332211);
    preload(6'd5, 32'h88776655);
    drive(1'b0, F_H, 32'h13, 32'h0);
    @(negedge CLK);
    vectors++;
    if ({Stall, Done} !== 2'b10 || LoadResult !== 32'h0) begin
      miscompares++;
      $display("FAIL lh_13_first got st/dn=%b lr=%h want 10 0", {Stall, Done}, LoadResult);
    end
    step();
    @(negedge CLK);
    vectors++;
    if ({Stall, Done} !== 2'b01 || LoadResult !== 32'h00005544 || DataAdr !== 32'h14) begin
      miscompares++;
      $display("FAIL lh_13_second got st/dn=%b lr=%h adr=%h", {Stall, Done}, LoadResult, DataAdr);
    end
    step();
    // Back-to-back: accepted in the cycle right after the second half.
    drive(1'b0, F_B, 32'h10, 32'h0);
    @(negedge CLK);
    vectors++;
    if (LoadResult !== 32'h00000011 || {Stall, Done} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_lb10 got %h st/dn=%b", LoadResult, {Stall, Done});
    end
    step();
    drive(1'b0, F_H, 32'h11, 32'h0);
    @(negedge CLK);
    vectors++;
    if (LoadResult !== 32'h00003322 || {Stall, Done} !== 2'b01) begin
      miscompares++;
      $display("FAIL lh_11_nosplit got %h st/dn=%b", LoadResult, {Stall, Done});
    end
    step();
    drive(1'b0, F_W, 32'h11, 32'h0);
    step();
    @(negedge CLK);
    vectors++;
    if (LoadResult !== 32'h55443322 || Done !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_11 got %h want 55443322", LoadResult);
    end
    step();
    MemReq = 1'b0;
  endtask

  task automatic test_wrap;
    preload(6'd63, 32'hDDCCBBAA);
    preload(6'd0, 32'h11223344);
    drive(1'b0, F_W, 32'hFFFFFFFE, 32'h0);
    @(negedge CLK);
    vectors++;
    if (DataAdr !== 32'hFFFFFFFC || Stall !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_first got adr=%h st=%b", DataAdr, Stall);
    end
    step();
    @(negedge CLK);
    vectors++;
    if (DataAdr !== 32'h0 || Done !== 1'b1 || LoadResult !== 32'h3344DDCC) begin
      miscompares++;
      $display("FAIL wrap_second got adr=%h dn=%b lr=%h", DataAdr, Done, LoadResult);
    end
    step();
    MemReq = 1'b0;
  endtask

  task automatic test_fault;
    drive(1'b0, 3'b011, 32'h10, 32'h0);
    @(negedge CLK);
    vectors++;
    if ({Fault, WE, web, Done, Stall} !== 8'b1_0_0000_00 || LoadResult !== 32'h0) begin
      miscompares++;
      $display("FAIL f3_011 got ft/we/web/dn/st=%b lr=%h", {Fault, WE, web, Done, Stall},
               LoadResult);
    end
    step();
    drive(1'b1, F_BU, 32'h10, 32'hFFFFFFFF);
    @(negedge CLK);
    vectors++;
    if ({Fault, WE, web} !== 6'b1_0_0000) begin
      miscompares++;
      $display("FAIL store_f3_100 got ft/we/web=%b want 100000", {Fault, WE, web});
    end
    step();
    drive(1'b0, F_W, 32'h10, 32'h0);
    @(negedge CLK);
    vectors++;
    if ({nm_fault, nm_done} !== 2'b01 || nm_lr !== 32'h44332211) begin
      miscompares++;
      $display("FAIL nm_lw10 got ft/dn=%b lr=%h", {nm_fault, nm_done}, nm_lr);
    end
    step();
    drive(1'b0, F_W, 32'h01, 32'h0);
    @(negedge CLK);
    vectors++;
    if ({nm_fault, nm_we, nm_stall, nm_done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL nm_lw01 got %b want 1000", {nm_fault, nm_we, nm_stall, nm_done});
    end
    step(); step();
    drive(1'b1, F_W, 32'h01, 32'h12345678);
    @(negedge CLK);
    vectors++;
    if ({nm_fault, nm_we, nm_web} !== 6'b10_0000) begin
      miscompares++;
      $display("FAIL nm_sw01 got %b want 100000", {nm_fault, nm_we, nm_web});
    end
    step(); step();
    MemReq = 1'b0;
  endtask

  task automatic test_reset_in_second;
    preload(6'd4, 32'h11111111);
    preload(6'd5, 32'h22222222);
    drive(1'b1, F_W, 32'h13, 32'hAABBCCDD);
    @(negedge CLK);
    vectors++;
    if (Stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rst2_first got st=%b want 1", Stall);
    end
    step();
    MemReq = 1'b0;
    RESET = 1'b1;
    #1;
    vectors++;
    if ({WE, web, Done, Stall} !== 7'b0) begin
      miscompares++;
      $display("FAIL rst2_during got %b want 0000000", {WE, web, Done, Stall});
    end
    step();
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({WE, Done, Stall} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst2_after got we/dn/st=%b want 000", {WE, Done, Stall});
    end
    step();
    vectors++;
    if (mem[4] !== 32'hDD111111 || mem[5] !== 32'h22222222) begin
      miscompares++;
      $display("FAIL rst2_mem got %h %h want dd111111 22222222", mem[4], mem[5]);
    end
    drive(1'b0, F_W, 32'h14, 32'h0);
    @(negedge CLK);
    vectors++;
    if (LoadResult !== 32'h22222222 || {Done, Stall} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst2_lw14 got lr=%h dn/st=%b", LoadResult, {Done, Stall});
    end
    step();
    MemReq = 1'b0;
  endtask

  initial begin
    MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; Adr = '0; StoreData = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned_store();
    test_misaligned_load();
    test_wrap();
    test_fault();
    test_reset_in_second();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "timeout");
  end

endmodule
